// File: rtl/cursor_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cursor_ctrl
//
// Turns single-cycle debounced direction pulses into a cursor position for the
// VGA pixel pipeline. Requests are collected into pending flags during a frame.
// They are applied only after frame_tick, so the drawn cursor never tears
// mid-frame.
//
// Ports:
//   clk        in   pixel clock, the only clock
//   rst_n      in   synchronous active-low reset
//   btn_up     in   single-cycle request: move up    (y - STEP)
//   btn_down   in   single-cycle request: move down  (y + STEP)
//   btn_left   in   single-cycle request: move left  (x - STEP)
//   btn_right  in   single-cycle request: move right (x + STEP)
//   frame_tick in   single-cycle pulse at start of vertical blanking
//   cur_x      out  registered cursor column, 0..H_MAX-1
//   cur_y      out  registered cursor row,    0..V_MAX-1
//   moved      out  one-cycle pulse when a position update is committed
//
// Build option:
//   CURSOR_WRAP_EN  when defined, edges wrap around instead of saturating.
// -----------------------------------------------------------------------------
module cursor_ctrl #(
  parameter int H_MAX = 640,
  parameter int V_MAX = 480,
  parameter int STEP  = 8,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          frame_tick,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          moved
);

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  // One extra bit on the intermediates so that x+STEP and x+H_MAX-STEP never overflow.
  localparam logic [XW:0]   H_SPAN = (XW+1)'(H_MAX);
  localparam logic [XW:0]   H_LAST = (XW+1)'(H_MAX - 1);
  localparam logic [XW:0]   X_STEP = (XW+1)'(STEP);
  localparam logic [YW:0]   V_SPAN = (YW+1)'(V_MAX);
  localparam logic [YW:0]   V_LAST = (YW+1)'(V_MAX - 1);
  localparam logic [YW:0]   Y_STEP = (YW+1)'(STEP);
  localparam logic [XW-1:0] X_HOME = XW'(H_MAX / 2);
  localparam logic [YW-1:0] Y_HOME = YW'(V_MAX / 2);

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

  state_t state, state_next;

  // Flag bit order: {up, down, left, right}
  logic [3:0]    btn;
  logic [3:0]    flags, flags_next;
  logic [3:0]    snap;
  logic          snap_load;
  logic          apply;
  logic          moved_next;
  logic [XW:0]   x_ext, x_inc;
  logic [YW:0]   y_ext, y_inc;
  logic [XW-1:0] x_next;
  logic [YW-1:0] y_next;

  assign btn = {btn_up, btn_down, btn_left, btn_right};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge, whatever the block order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (|btn) state_next = PENDING;
      PENDING: if (frame_tick) state_next = APPLY;
      // Flags still set here were raised on the snapshot cycle or during APPLY.
      APPLY:   state_next = (|flags || |btn) ? PENDING : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    snap_load  = (state == PENDING) && frame_tick;
    apply      = (state == APPLY);
    // A pulse that lands on the snapshot tick survives the clear and is
    // applied in the next frame.
    flags_next = snap_load ? btn : (flags | btn);
    // Opposite requests on the same axis cancel each other.
    moved_next = apply && ((snap[3] ^ snap[2]) || (snap[1] ^ snap[0]));

    x_ext  = {1'b0, cur_x};
    x_inc  = x_ext + X_STEP;
    x_next = cur_x;
    if (snap[0] && !snap[1]) begin
      if (x_inc > H_LAST) x_next = WRAP ? XW'(x_inc - H_SPAN) : XW'(H_LAST);
      else                x_next = XW'(x_inc);
    end else if (snap[1] && !snap[0]) begin
      if (x_ext < X_STEP) x_next = WRAP ? XW'(x_ext + H_SPAN - X_STEP) : '0;
      else                x_next = XW'(x_ext - X_STEP);
    end

    y_ext  = {1'b0, cur_y};
    y_inc  = y_ext + Y_STEP;
    y_next = cur_y;
    if (snap[2] && !snap[3]) begin
      if (y_inc > V_LAST) y_next = WRAP ? YW'(y_inc - V_SPAN) : YW'(V_LAST);
      else                y_next = YW'(y_inc);
    end else if (snap[3] && !snap[2]) begin
      if (y_ext < Y_STEP) y_next = WRAP ? YW'(y_ext + V_SPAN - Y_STEP) : '0;
      else                y_next = YW'(y_ext - Y_STEP);
    end
  end

  // ---------------------------------------------------------------------------
  // Flag, snapshot and position registers
  // ---------------------------------------------------------------------------
  // Reset wins over everything, so a reset during APPLY discards the update
  // and suppresses the moved pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags <= '0;
      snap  <= '0;
      cur_x <= X_HOME;
      cur_y <= Y_HOME;
      moved <= 1'b0;
    end else begin
      flags <= flags_next;
      if (snap_load) snap <= flags;
      if (apply) begin
        cur_x <= x_next;
        cur_y <= y_next;
      end
      moved <= moved_next;
    end
  end

endmodule
